// File: rtl/aibcr3_rxmode_pkg.sv
// Package for the AIB RX mode-change sequencer.
// Holds the receive-enable code constants, the code validity / data-mode
// helpers and the sequencer state encoding.
package aibcr3_rxmode_pkg;

    localparam logic [2:0] RXEN_ASYNC = 3'b000;
    localparam logic [2:0] RXEN_DDR   = 3'b001;
    localparam logic [2:0] RXEN_DIS   = 3'b010;
    localparam logic [2:0] RXEN_CLK   = 3'b011;
    localparam logic [2:0] RXEN_SDR   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISABLE = 3'd1,
        ST_APPLY   = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic is_valid_mode(input logic [2:0] m);
        return (m == RXEN_ASYNC) || (m == RXEN_DDR) || (m == RXEN_DIS) ||
               (m == RXEN_CLK)   || (m == RXEN_SDR);
    endfunction

    // Modes that produce sampled data; clock mode and disabled do not.
    function automatic logic is_data_mode(input logic [2:0] m);
        return (m == RXEN_ASYNC) || (m == RXEN_DDR) || (m == RXEN_SDR);
    endfunction

endpackage

// File: rtl/aibcr3_rxmode_if.sv
// Interface bundling the request handshake and the datapath control outputs.
// Handshake: the requester raises ireq (level) with imode; the sequencer
// samples imode only in IDLE and answers with a one-cycle oack (plus oerr for
// an invalid code). The requester drops ireq in the cycle oack is high; ireq
// still high in the following cycle is a new request. ireq/imode are ignored
// while obusy is high.
//   master : requester / configuration side (drives ireq, imode)
//   slave  : sequencer (drives everything else)
interface aibcr3_rxmode_if;
    logic       ireq;
    logic [2:0] imode;
    logic       oack;
    logic       oerr;
    logic       obusy;
    logic [2:0] orxen;
    logic       orstb;
    logic [2:0] omode_cur;
    logic       orx_valid;

    modport master (
        output ireq, imode,
        input  oack, oerr, obusy, orxen, orstb, omode_cur, orx_valid
    );

    modport slave (
        input  ireq, imode,
        output oack, oerr, obusy, orxen, orstb, omode_cur, orx_valid
    );
endinterface

// File: rtl/aibcr3_rxmode_cnt.sv
// Loadable down-counter used as the phase timer of the sequencer.
// Ports: clk/rst (async active-high), load + load_val (load wins over en),
// en (decrement, saturating at zero), cnt (current value), zero (cnt == 0).
module aibcr3_rxmode_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aibcr3_rxmode_seq.sv
// RX mode-change sequencer for one AIB receive IO.
// On an accepted request it disables the receiver, applies the new code under
// datapath reset, releases reset, waits for the sync pipeline to flush, then
// pulses oack. Same-code requests and invalid codes complete at once without
// touching the datapath controls.
// Ports: iclk, irst (async active-high), bus (slave side of aibcr3_rxmode_if),
//        odbg_state (current sequencer state, for observation).
module aibcr3_rxmode_seq
    import aibcr3_rxmode_pkg::*;
#(
    parameter int DIS_CYC    = 4,
    parameter int SETTLE_CYC = 4,
    parameter int FLUSH_CYC  = 3,
    parameter int CNT_W      = 4
) (
    input  logic                  iclk,
    input  logic                  irst,
    aibcr3_rxmode_if.slave        bus,
    output logic [2:0]            odbg_state
);

    state_e     state_q, state_d;
    logic [2:0] mode_req_q, mode_req_d;
    logic       err_q, err_d;
    logic [2:0] rxen_q, rxen_d;
    logic       rstb_q, rstb_d;
    logic [2:0] cur_q, cur_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_unused;
    logic             cnt_zero;

    // Each phase loads N-1 on entry and leaves when the counter reads zero,
    // so the phase lasts exactly N cycles.
    aibcr3_rxmode_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (iclk),
        .rst      (irst),
        .load     (cnt_load),
        .en       (!cnt_load),
        .load_val (cnt_val),
        .cnt      (cnt_unused),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        mode_req_d = mode_req_q;
        err_d      = err_q;
        rxen_d     = rxen_q;
        rstb_d     = rstb_q;
        cur_d      = cur_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.ireq) begin
                    mode_req_d = bus.imode;
                    if (!is_valid_mode(bus.imode)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus.imode == cur_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_DISABLE;
                        rxen_d   = RXEN_DIS;
                        rstb_d   = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(DIS_CYC - 1);
                    end
                end
            end
            ST_DISABLE: begin
                if (cnt_zero) begin
                    state_d  = ST_APPLY;
                    rxen_d   = mode_req_q;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(SETTLE_CYC - 1);
                end
            end
            ST_APPLY: begin
                if (cnt_zero) begin
                    state_d  = ST_FLUSH;
                    rstb_d   = 1'b1;
                    cur_d    = mode_req_q;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(FLUSH_CYC - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q    <= ST_IDLE;
            mode_req_q <= RXEN_DIS;
            err_q      <= 1'b0;
            rxen_q     <= RXEN_DIS;
            rstb_q     <= 1'b0;
            cur_q      <= RXEN_DIS;
        end else begin
            state_q    <= state_d;
            mode_req_q <= mode_req_d;
            err_q      <= err_d;
            rxen_q     <= rxen_d;
            rstb_q     <= rstb_d;
            cur_q      <= cur_d;
        end
    end

    assign bus.oack      = (state_q == ST_DONE);
    assign bus.oerr      = (state_q == ST_DONE) && err_q;
    assign bus.obusy     = (state_q != ST_IDLE);
    assign bus.orxen     = rxen_q;
    assign bus.orstb     = rstb_q;
    assign bus.omode_cur = cur_q;
    // Data is qualified only when idle, out of reset and in a data mode.
    assign bus.orx_valid = (state_q == ST_IDLE) && rstb_q && is_data_mode(cur_q);
    assign odbg_state    = state_q;

endmodule
